// File: rtl/my_fifo.sv
// Synchronous first-word fall-through FIFO built on a circular buffer.
// Occupancy is tracked explicitly so full/empty never need pointer tricks.
module my_fifo #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_valid,
  input  logic [C_DATA_WIDTH-1:0]           write_data,
  output logic                              write_ready,
  output logic                              read_valid,
  input  logic                              read_ready,
  output logic [C_DATA_WIDTH-1:0]           read_data,
  output logic [$clog2(C_FIFO_DEPTH):0]     size,
  output logic                              empty,
  output logic                              full
);

  localparam int PTR_W  = $clog2(C_FIFO_DEPTH);
  localparam int SIZE_W = PTR_W + 1;

  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [SIZE_W-1:0]       count;
  logic                    do_write;
  logic                    do_read;

  // Handshake flags come from registered occupancy only, so no input reaches them.
  assign full        = (count == SIZE_W'(C_FIFO_DEPTH));
  assign empty       = (count == '0);
  assign write_ready = !full;
  assign read_valid  = !empty;
  assign size        = count;
  assign read_data   = mem[rd_ptr];

  assign do_write = write_valid && write_ready;
  assign do_read  = read_valid && read_ready;

  // Depth is a power of two, so the pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_write, do_read})
        2'b10:   count <= count + SIZE_W'(1);
        2'b01:   count <= count - SIZE_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; a write during reset is harmless
  // because the pointers are cleared on the same edge.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= write_data;
    end
  end

endmodule

// File: tb/tb_my_fifo.sv
// Self-checking bench for my_fifo: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_my_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          write_valid;
  logic [DW-1:0] write_data;
  logic          write_ready;
  logic          read_valid;
  logic          read_ready;
  logic [DW-1:0] read_data;
  logic [2:0]    size;
  logic          empty;
  logic          full;

  int num_checks = 0;
  int num_fails  = 0;

  my_fifo #(.C_DATA_WIDTH(DW), .C_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .write_valid(write_valid),
    .write_data(write_data),
    .write_ready(write_ready),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .read_data(read_data),
    .size(size),
    .empty(empty),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    int            exp_size;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [18];

  // Drive one cycle of inputs, let the edge happen, and return just after it.
  task automatic applyStimulus(input logic rst, input logic wv,
                               input logic [DW-1:0] wd, input logic rr);
    reset       = rst;
    write_valid = wv;
    write_data  = wd;
    read_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Everything observable follows from occupancy, plus the head word when non-empty.
  task automatic checkState(input string name, input int exp_size,
                            input logic [DW-1:0] exp_data);
    checkOutput({name, ".size"}, DW'(size), DW'(exp_size));
    checkOutput({name, ".empty"}, DW'(empty), DW'(exp_size == 0));
    checkOutput({name, ".full"}, DW'(full), DW'(exp_size == DEPTH));
    checkOutput({name, ".read_valid"}, DW'(read_valid), DW'(exp_size != 0));
    checkOutput({name, ".write_ready"}, DW'(write_ready), DW'(exp_size != DEPTH));
    if (exp_size != 0)
      checkOutput({name, ".read_data"}, read_data, exp_data);
  endtask

  task automatic fillVectors();
    vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 0, 32'h00};
    vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1, 32'h11};
    vecs[3]  = '{1'b0, 1'b1, 32'h22, 1'b0, 2, 32'h11};
    vecs[4]  = '{1'b0, 1'b1, 32'h33, 1'b0, 3, 32'h11};
    vecs[5]  = '{1'b0, 1'b1, 32'h44, 1'b0, 4, 32'h11};
    vecs[6]  = '{1'b0, 1'b1, 32'hFF, 1'b0, 4, 32'h11};
    vecs[7]  = '{1'b0, 1'b1, 32'hEE, 1'b1, 3, 32'h22};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2, 32'h33};
    vecs[9]  = '{1'b0, 1'b1, 32'h55, 1'b1, 2, 32'h44};
    vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 1, 32'h55};
    vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 32'h00};
    vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 32'h00};
    vecs[13] = '{1'b0, 1'b1, 32'h66, 1'b1, 1, 32'h66};
    vecs[14] = '{1'b0, 1'b1, 32'h77, 1'b0, 2, 32'h66};
    vecs[15] = '{1'b0, 1'b1, 32'h88, 1'b0, 3, 32'h66};
    vecs[16] = '{1'b1, 1'b1, 32'h99, 1'b1, 0, 32'h00};
    vecs[17] = '{1'b0, 1'b0, 32'h00, 1'b0, 0, 32'h00};
  endtask

  logic [DW-1:0] model_q [$];

  initial begin
    reset       = 1'b1;
    write_valid = 1'b0;
    write_data  = '0;
    read_ready  = 1'b0;

    fillVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      checkState($sformatf("vec%0d", i), vecs[i].exp_size, vecs[i].exp_data);
    end

    // Fill to full, confirm an extra write is dropped, then drain in order.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkState("full.reset", 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(32'hA0 + i), 1'b0);
      checkState($sformatf("full.wr%0d", i), i + 1, 32'hA0);
    end
    applyStimulus(1'b0, 1'b1, 32'hFF, 1'b0);
    checkState("full.drop", DEPTH, 32'hA0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("drain.data%0d", i), read_data, DW'(32'hA0 + i));
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput($sformatf("drain.size%0d", i), DW'(size), DW'(DEPTH - 1 - i));
    end
    checkState("drain.end", 0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkState("drain.idle", 0, '0);

    // Hold occupancy at two while streaming ten words through the wrapping pointers.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd1, 1'b0);
    checkState("wrap.prefill", 2, 32'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("wrap.data%0d", i), read_data, DW'(i));
      applyStimulus(1'b0, 1'b1, DW'(i + 2), 1'b1);
      checkOutput($sformatf("wrap.size%0d", i), DW'(size), 32'd2);
    end
    checkState("wrap.end", 2, 32'd8);

    // Reset in the middle of traffic discards everything stored.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, DW'(32'hC0 + i), 1'b0);
    checkState("midrst.pre", 3, 32'hC0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkState("midrst.post", 0, '0);

    // Randomized traffic compared against a queue holding the accepted words.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    model_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic          r_rst;
      logic          r_wv;
      logic          r_rr;
      logic [DW-1:0] r_wd;
      logic          accept_w;
      logic          accept_r;
      r_rst = ($urandom_range(0, 49) == 0);
      r_wv  = ($urandom_range(0, 99) < 60);
      r_rr  = ($urandom_range(0, 99) < 50);
      r_wd  = DW'($urandom);
      accept_w = r_wv && (model_q.size() < DEPTH);
      accept_r = r_rr && (model_q.size() > 0);
      applyStimulus(r_rst, r_wv, r_wd, r_rr);
      if (r_rst) begin
        model_q.delete();
      end else begin
        if (accept_r) void'(model_q.pop_front());
        if (accept_w) model_q.push_back(r_wd);
      end
      checkState($sformatf("rand%0d", cyc), model_q.size(),
                 (model_q.size() != 0) ? model_q[0] : '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/my_fifo.md
MY_FIFO -- requirements
Module: my_fifo

Interface
REQ-001 The block SHALL have parameter C_DATA_WIDTH, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter C_FIFO_DEPTH, default 4, meaning the entry count; it must be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port write_valid, input, 1 bit: the producer offers write_data.
REQ-006 The block SHALL have port write_data, input, C_DATA_WIDTH bits: the word to store.
REQ-007 The block SHALL have port write_ready, output, 1 bit: the FIFO can accept a word.
REQ-008 The block SHALL have port read_valid, output, 1 bit: read_data holds the oldest stored word.
REQ-009 The block SHALL have port read_ready, input, 1 bit: the consumer takes read_data.
REQ-010 The block SHALL have port read_data, output, C_DATA_WIDTH bits: the head word.
REQ-011 The block SHALL have port size, output, $clog2(C_FIFO_DEPTH)+1 bits: the current occupancy, 0..C_FIFO_DEPTH.
REQ-012 The block SHALL have port empty, output, 1 bit: asserted when size==0.
REQ-013 The block SHALL have port full, output, 1 bit: asserted when size==C_FIFO_DEPTH.

Function
REQ-014 Storage SHALL be a circular buffer with write and read pointers, each $clog2(C_FIFO_DEPTH) bits, that wrap from C_FIFO_DEPTH-1 to 0.
REQ-015 Output timing SHALL be:
- write_ready = !full, read_valid = !empty.
- Both derive from registered state only; there is no combinational path from read_ready or write_valid.
REQ-016 A write SHALL occur when write_valid && write_ready:
- write_data is stored at the write pointer on that edge.
- The write pointer advances by 1.
REQ-017 A write_valid asserted while full SHALL be ignored: data dropped, no state change, even if a read occurs in the same cycle.
REQ-018 Reads SHALL be first-word fall-through:
- read_data is combinationally the entry at the read pointer.
- The word is valid in the same cycle read_valid rises; there are no added read-latency cycles.
REQ-019 A read SHALL occur when read_valid && read_ready; the read pointer advances by 1 on that edge.
REQ-020 read_ready while empty SHALL have no effect.
REQ-021 read_data while empty SHALL be don't-care and must not be checked.
REQ-022 Write-to-read latency SHALL be one cycle: a word written at edge N appears on read_data with read_valid=1 in the cycle after edge N.
REQ-023 size SHALL update each edge:
- +1 for write only, -1 for read only.
- Unchanged for both or neither.
- size never exceeds C_FIFO_DEPTH and never underflows below 0.
REQ-024 A simultaneous read and write while empty SHALL perform the write only: size 0->1.
REQ-025 A simultaneous read and write with 0<size<C_FIFO_DEPTH SHALL perform both, with size unchanged.
REQ-026 Data SHALL leave in strict arrival order with no duplication or loss of accepted words.

Reset
REQ-027 While reset=1 at a rising edge, the FIFO SHALL set:
- both pointers = 0 and size = 0;
- empty=1, full=0, read_valid=0, write_ready=1.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 Reset SHALL take priority over simultaneous read and write in the same cycle.
REQ-030 Reset asserted mid-operation SHALL discard all stored words.

Verification (C_DATA_WIDTH=32, C_FIFO_DEPTH=4)
REQ-031 Reset then idle -> size=0, empty=1, full=0, read_valid=0, write_ready=1.
REQ-032 Write 0x11, 0x22 on consecutive cycles, read_ready=0 ->
- size=1, then size=2;
- read_data=0x11 with read_valid=1 the cycle after the first write.
REQ-033 Write 0xA0..0xA3 with no reads -> full=1, write_ready=0, size=4; a further write of 0xFF is dropped.
REQ-034 Drain after REQ-033 with read_ready=1 -> reads return 0xA0, 0xA1, 0xA2, 0xA3 in order; then empty=1 and 0xFF never appears.
REQ-035 Wrap-around -> hold size=2 with simultaneous reads and writes for 10 cycles writing 0..9; reads return 0..7 in order, size stays 2, and pointers wrap.
REQ-036 Reset mid-operation -> with size=3, assert reset for one cycle; next cycle size=0, empty=1, read_valid=0.
